dmem_periph_responder: RTL and testbench

//  Memory-side responder for the pipelined CPU's MEM-stage data bus, the other end of the
//  CPU's address / write-data / write-enable / read-data port.

---
 rtl/dmem_periph_responder_pkg.sv | 36 +++
 rtl/dmem_periph_responder_seg7_hex_decode.sv | 11 +
 rtl/dmem_periph_responder.sv | 126 ++++++++++++
 tb/tb_dmem_periph_responder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dmem_periph_responder_pkg.sv
// Shared constants for the MEM-stage data bus responder: address map, RAM sizing,
// decode targets and the active-low hex glyph table.
package dmem_periph_responder_pkg;

  localparam logic [31:0] MMIO_SEG = 32'hFFFF_F000;
  localparam logic [31:0] MMIO_LED = 32'hFFFF_F060;
  localparam logic [31:0] MMIO_SW  = 32'hFFFF_F070;
  localparam logic [31:0] MMIO_BTN = 32'hFFFF_F078;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;

  // Byte span of a RAM with 2**aw words; 33 bits so aw up to 30 cannot overflow.
  function automatic logic [32:0] ram_span(input int aw);
    return 33'd4 << aw;
  endfunction

  function automatic logic in_ram(input logic [31:0] addr, input int aw);
    return ({1'b0, addr} - {1'b0, RAM_BASE}) < ram_span(aw);
  endfunction

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_RAM,
    TGT_SEG,
    TGT_LED,
    TGT_SW,
    TGT_BTN
  } target_e;

  // Segment order {DP,G,F,E,D,C,B,A}, active-low, DP always dark.
  localparam logic [7:0] HEX_FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/dmem_periph_responder_seg7_hex_decode.sv
// Nibble to active-low 7-segment glyph, purely combinational.
module seg7_hex_decode
  import dmem_periph_responder_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] segments
);

  assign segments = HEX_FONT[nibble];

endmodule

// File: rtl/dmem_periph_responder.sv
// Data-bus responder: word-addressed RAM plus LED/switch/button/7-segment MMIO,
// with same-cycle combinational read data for the CPU MEM stage.
module dmem_periph_responder
  import dmem_periph_responder_pkg::*;
#(
  parameter int RAM_AW   = 12,
  parameter int SCAN_DIV = 20000,
  parameter int SW_W     = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  input  logic            we_i,
  output logic [31:0]     rdata_o,
  input  logic [SW_W-1:0] sw_i,
  input  logic [4:0]      btn_i,
  output logic [SW_W-1:0] led_o,
  output logic [7:0]      dig_en_o,
  output logic [7:0]      seg_o
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  target_e             target;
  logic [RAM_AW-1:0]   ram_idx;
  logic [31:0]         ram [2**RAM_AW];

  logic [31:0]         seg_reg;
  logic [SW_W-1:0]     led_reg;
  logic [SW_W-1:0]     sw_meta_reg, sw_sync_reg;
  logic [4:0]          btn_meta_reg, btn_sync_reg;
  logic [CNT_W-1:0]    scan_cnt_reg;
  logic [2:0]          dig_idx_reg;
  logic [7:0]          dig_en_reg, seg_out_reg;
  logic [3:0]          cur_nibble;
  logic [7:0]          cur_glyph;

  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[1:0];

  assign ram_idx = addr_i[RAM_AW+1:2];

  always_comb begin
    target = TGT_NONE;
    if (in_ram(addr_i, RAM_AW)) begin
      target = TGT_RAM;
    end else begin
      case ({addr_i[31:2], 2'b00})
        MMIO_SEG: target = TGT_SEG;
        MMIO_LED: target = TGT_LED;
        MMIO_SW:  target = TGT_SW;
        MMIO_BTN: target = TGT_BTN;
        default:  target = TGT_NONE;
      endcase
    end
  end

  // RAM is deliberately outside the reset domain so stores during rst still land.
  always_ff @(posedge clk) begin
    if (we_i && target == TGT_RAM) ram[ram_idx] <= wdata_i;
  end

  always_comb begin
    rdata_o = 32'h0;
    case (target)
      TGT_RAM: rdata_o = ram[ram_idx];
      TGT_SEG: rdata_o = seg_reg;
      TGT_LED: rdata_o = 32'(led_reg);
      TGT_SW:  rdata_o = 32'(sw_sync_reg);
      TGT_BTN: rdata_o = 32'(btn_sync_reg);
      default: rdata_o = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg      <= '0;
      led_reg      <= '0;
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      btn_meta_reg <= '0;
      btn_sync_reg <= '0;
    end else begin
      sw_meta_reg  <= sw_i;
      sw_sync_reg  <= sw_meta_reg;
      btn_meta_reg <= btn_i;
      btn_sync_reg <= btn_meta_reg;
      if (we_i && target == TGT_SEG) seg_reg <= wdata_i;
      if (we_i && target == TGT_LED) led_reg <= wdata_i[SW_W-1:0];
    end
  end

  // Outputs are re-registered every cycle from live SEG, so a mid-scan write
  // shows up on the next update without ever reverting to old data.
  assign cur_nibble = seg_reg[{dig_idx_reg, 2'b00} +: 4];

  seg7_hex_decode u_hex (
    .nibble   (cur_nibble),
    .segments (cur_glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_reg <= '0;
      dig_idx_reg  <= '0;
      dig_en_reg   <= 8'hFE;
      seg_out_reg  <= 8'hC0;
    end else begin
      if (scan_cnt_reg == CNT_LAST) begin
        scan_cnt_reg <= '0;
        dig_idx_reg  <= dig_idx_reg + 3'd1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + 1'b1;
      end
      dig_en_reg  <= ~(8'b1 << dig_idx_reg);
      seg_out_reg <= {1'b1, cur_glyph[6:0]};
    end
  end

  assign led_o    = led_reg;
  assign dig_en_o = dig_en_reg;
  assign seg_o    = seg_out_reg;

endmodule

// File: tb/tb_dmem_periph_responder.sv
// Directed bench for dmem_periph_responder: RAM, MMIO registers, synchronizers,
// display scan and reset behaviour, checked against hand-computed values.
module tb_dmem_periph_responder;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [23:0] sw;
  logic [4:0]  btn;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;
  logic [7:0] font [16];

  dmem_periph_responder #(
    .RAM_AW   (12),
    .SCAN_DIV (4),
    .SW_W     (24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .we_i     (we),
    .rdata_o  (rdata),
    .sw_i     (sw),
    .btn_i    (btn),
    .led_o    (led),
    .dig_en_o (dig_en),
    .seg_o    (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k counts rising edges since the last edge that saw rst high.
  task automatic tick();
    @(posedge clk);
    if (rst) k = 0;
    else k++;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; we = 1'b0;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    logic [7:0] exp_en;
    int idx;
    font[0]  = 8'hC0; font[1]  = 8'hF9; font[2]  = 8'hA4; font[3]  = 8'hB0;
    font[4]  = 8'h99; font[5]  = 8'h92; font[6]  = 8'h82; font[7]  = 8'hF8;
    font[8]  = 8'h80; font[9]  = 8'h90; font[10] = 8'h88; font[11] = 8'h83;
    font[12] = 8'hC6; font[13] = 8'hA1; font[14] = 8'h86; font[15] = 8'h8E;

    rst = 1'b1; addr = 32'h0; wdata = 32'h0; we = 1'b0; sw = '0; btn = '0;
    tick();
    tick();
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_dig_en", 32'(dig_en), 32'hFE);
    chk("rst_seg", 32'(seg), 32'hC0);
    rd("rst_led_read", 32'hFFFF_F060, 32'h0);

    // Display scan, SEG written on the first edge after reset release.
    rst = 1'b0;
    wr(32'hFFFF_F000, 32'h7654_3210);
    rd("seg_read", 32'hFFFF_F000, 32'h7654_3210);
    for (int i = 0; i < 35; i++) begin
      tick();
      if (k >= 4) begin
        idx = ((k - 1) / 4) % 8;
        exp_en = ~(8'b1 << idx);
        chk($sformatf("scan_en_k%0d", k), 32'(dig_en), 32'(exp_en));
        chk($sformatf("scan_seg_k%0d", k), 32'(seg), 32'(font[idx]));
      end
    end

    // RAM write, read-back, neighbour untouched.
    wr(32'h0000_0000, 32'h1111_1111);
    wr(32'h0000_0014, 32'hCAFE_F00D);
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_14", 32'h0000_0014, 32'hCAFE_F00D);
    rd("ram_top_unset_alias", 32'h0000_3FFC + 32'h4, 32'h0);

    // Same-cycle read/write shows the old word.
    wr(32'h0000_0020, 32'h0000_0005);
    addr = 32'h0000_0020; wdata = 32'h1; we = 1'b1;
    #1;
    chk("raw_old", rdata, 32'h5);
    tick();
    we = 1'b0;
    #1;
    chk("raw_new", rdata, 32'h1);

    // LED register.
    wr(32'hFFFF_F060, 32'h00AB_CDEF);
    chk("led_out", 32'(led), 32'h00AB_CDEF);
    rd("led_read", 32'hFFFF_F060, 32'h00AB_CDEF);

    // Two-edge synchronizer latency on switches and buttons.
    sw = 24'h12_3456; btn = 5'h15;
    rd("sw_edge0", 32'hFFFF_F070, 32'h0);
    tick();
    rd("sw_edge1", 32'hFFFF_F070, 32'h0);
    rd("btn_edge1", 32'hFFFF_F078, 32'h0);
    tick();
    rd("sw_edge2", 32'hFFFF_F070, 32'h0012_3456);
    rd("btn_edge2", 32'hFFFF_F078, 32'h0000_0015);

    // Unmapped and read-only writes are dropped.
    wr(32'h8000_0000, 32'h0000_0055);
    wr(32'hFFFF_F070, 32'h0000_00AA);
    rd("unmapped_read", 32'h8000_0000, 32'h0);
    rd("sw_after_write", 32'hFFFF_F070, 32'h0012_3456);
    rd("unmapped_f004", 32'hFFFF_F004, 32'h0);
    rd("ram_0_intact", 32'h0000_0000, 32'h1111_1111);
    chk("led_intact", 32'(led), 32'h00AB_CDEF);

    // Reset mid-scan at digit 5, with a register store that must be ignored.
    for (int i = 0; i < 40 && ((k / 4) % 8) != 5; i++) tick();
    if (((k / 4) % 8) != 5) begin
      vectors++;
      miscompares++;
      $error("FAIL reach_digit5: observed k=%0d expected digit 5 within bound", k);
    end
    rst = 1'b1; addr = 32'hFFFF_F060; wdata = 32'h77; we = 1'b1;
    tick();
    chk("rst5_dig_en", 32'(dig_en), 32'hFE);
    chk("rst5_seg", 32'(seg), 32'hC0);
    chk("rst5_led", 32'(led), 32'h0);
    rst = 1'b0; we = 1'b0;
    rd("rst5_ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("rst5_seg_reg", 32'hFFFF_F000, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("rst5_k4_dig_en", 32'(dig_en), 32'hFE);
    tick();
    chk("rst5_k5_dig_en", 32'(dig_en), 32'hFD);
    chk("rst5_k5_seg", 32'(seg), 32'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
